// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: state encoding,
// default parameter values and a helper for sizing the program-select port.
package pc_sequencer_pkg;

  localparam int PW_DEF      = 10;
  localparam int CW_DEF      = 16;
  localparam int NPROG_DEF   = 4;
  localparam int PSTRIDE_DEF = 256;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } pcState_e;

  // Width of the program-select field; never narrower than one bit.
  function automatic int selWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pc_sequencer_sat_counter.sv
// Saturating up-counter used for both the cycle and instruction counts.
// A clear wins over an increment; the count sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  // Count register: async reset, synchronous clear, saturating increment.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: launches one of NPROG programs at a fixed
// stride, steps/branches the PC while running, and counts cycles and
// retired instructions until HALT.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int PW      = PW_DEF,
  parameter int CW      = CW_DEF,
  parameter int NPROG   = NPROG_DEF,
  parameter int PSTRIDE = PSTRIDE_DEF
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         Start,
  input  logic [selWidth(NPROG)-1:0]   ProgSel,
  input  logic                         Halt,
  input  logic                         Stall,
  input  logic                         BranchAbs,
  input  logic                         BranchRelEn,
  input  logic                         ALU_flag,
  input  logic [PW-1:0]                Target,
  input  logic [PW-1:0]                Offset,
  output logic [PW-1:0]                ProgCtr,
  output logic                         Running,
  output logic                         Ack,
  output logic [CW-1:0]                CycleCt,
  output logic [CW-1:0]                InstCt
);

  pcState_e      state_r;
  logic [PW-1:0] launchPc_s;
  logic          cycleEn_s;
  logic          instEn_s;

  // Start vector of the selected program; out-of-range selects fall back to program 0.
  always_comb begin
    if (32'(ProgSel) >= NPROG) begin
      launchPc_s = '0;
    end else begin
      launchPc_s = PW'(ProgSel) * PW'(PSTRIDE);
    end
  end

  // Counter enables: every RUN cycle counts, only non-stalled cycles retire.
  always_comb begin
    if (state_r == ST_RUN) begin
      cycleEn_s = 1'b1;
      instEn_s  = ~Stall;
    end else begin
      cycleEn_s = 1'b0;
      instEn_s  = 1'b0;
    end
  end

  // Sequencer FSM with registered PC and status outputs; Start overrides everything.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r <= ST_IDLE;
      ProgCtr <= '0;
      Running <= 1'b0;
      Ack     <= 1'b0;
    end else if (Start) begin
      state_r <= ST_RUN;
      ProgCtr <= launchPc_s;
      Running <= 1'b1;
      Ack     <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (Stall) begin
            ProgCtr <= ProgCtr;
          end else if (Halt) begin
            state_r <= ST_DONE;
            Running <= 1'b0;
            Ack     <= 1'b1;
          end else if (BranchAbs) begin
            ProgCtr <= Target;
          end else if (BranchRelEn && ALU_flag) begin
            ProgCtr <= ProgCtr + Offset;
          end else begin
            ProgCtr <= ProgCtr + PW'(1);
          end
        end
        ST_IDLE, ST_DONE: begin
          ProgCtr <= ProgCtr;
        end
        default: begin
          state_r <= ST_IDLE;
          ProgCtr <= '0;
          Running <= 1'b0;
          Ack     <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.W(CW)) uCycleCtr (
    .Clk   (Clk),
    .Reset (Reset),
    .clr   (Start),
    .en    (cycleEn_s),
    .q     (CycleCt)
  );

  sat_counter #(.W(CW)) uInstCtr (
    .Clk   (Clk),
    .Reset (Reset),
    .clr   (Start),
    .en    (instEn_s),
    .q     (InstCt)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by
// randomized traffic, all checked against a behavioural model. A second
// instance with CW=4 and NPROG=3 exercises saturation and out-of-range select.
module tb_pc_sequencer;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic [1:0] ProgSel = 2'd0;
  logic       Halt = 1'b0, Stall = 1'b0, BranchAbs = 1'b0, BranchRelEn = 1'b0, ALU_flag = 1'b0;
  logic [9:0] Target = 10'd0, Offset = 10'd0;

  logic [9:0]  ProgCtr, ProgCtr4;
  logic        Running, Ack, Running4, Ack4;
  logic [15:0] CycleCt, InstCt;
  logic [3:0]  CycleCt4, InstCt4;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int mPc = 0, mCyc = 0, mInst = 0;
  bit mRun = 0, mDone = 0;

  always #5 Clk = ~Clk;

  pc_sequencer dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel), .Halt(Halt),
    .Stall(Stall), .BranchAbs(BranchAbs), .BranchRelEn(BranchRelEn),
    .ALU_flag(ALU_flag), .Target(Target), .Offset(Offset), .ProgCtr(ProgCtr),
    .Running(Running), .Ack(Ack), .CycleCt(CycleCt), .InstCt(InstCt)
  );

  pc_sequencer #(.CW(4), .NPROG(3)) dut4 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel), .Halt(Halt),
    .Stall(Stall), .BranchAbs(BranchAbs), .BranchRelEn(BranchRelEn),
    .ALU_flag(ALU_flag), .Target(Target), .Offset(Offset), .ProgCtr(ProgCtr4),
    .Running(Running4), .Ack(Ack4), .CycleCt(CycleCt4), .InstCt(InstCt4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic modelEdge();
    if (Reset) begin
      mPc = 0; mCyc = 0; mInst = 0; mRun = 0; mDone = 0;
    end else if (Start) begin
      mPc = (int'(ProgSel) * 256) % 1024;
      mCyc = 0; mInst = 0; mRun = 1; mDone = 0;
    end else if (mRun) begin
      mCyc++;
      if (!Stall) begin
        mInst++;
        if (Halt) begin
          mRun = 0; mDone = 1;
        end else if (BranchAbs) begin
          mPc = int'(Target);
        end else if (BranchRelEn && ALU_flag) begin
          mPc = (mPc + int'(Offset)) % 1024;
        end else begin
          mPc = (mPc + 1) % 1024;
        end
      end
    end
  endtask

  task automatic compareAll(input string tag);
    check({tag, "_pc"},    32'(ProgCtr),  32'(mPc));
    check({tag, "_run"},   32'(Running),  32'(mRun));
    check({tag, "_ack"},   32'(Ack),      32'(mDone));
    check({tag, "_cyc"},   32'(CycleCt),  32'(sat(mCyc, 65535)));
    check({tag, "_inst"},  32'(InstCt),   32'(sat(mInst, 65535)));
    check({tag, "_cyc4"},  32'(CycleCt4), 32'(sat(mCyc, 15)));
    check({tag, "_inst4"}, 32'(InstCt4),  32'(sat(mInst, 15)));
  endtask

  // Apply one cycle of inputs at the falling edge, clock it, then compare.
  task automatic cyc(input string tag, input bit st, input int sel, input bit h, input bit s,
                     input bit ba, input bit br, input bit f, input int tg, input int off);
    logic [31:0] tgv, offv, selv;
    tgv = 32'(tg); offv = 32'(off); selv = 32'(sel);
    @(negedge Clk);
    Start = st; ProgSel = selv[1:0]; Halt = h; Stall = s;
    BranchAbs = ba; BranchRelEn = br; ALU_flag = f;
    Target = tgv[9:0]; Offset = offv[9:0];
    @(posedge Clk);
    modelEdge();
    #1;
    compareAll(tag);
  endtask

  task automatic idle(input string tag);
    cyc(tag, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    int c0, i0;
    // Reset state
    #1;
    check("reset_pc", 32'(ProgCtr), 32'd0);
    check("reset_run", 32'(Running), 32'd0);
    check("reset_ack", 32'(Ack), 32'd0);
    check("reset_cyc", 32'(CycleCt), 32'd0);
    check("reset_inst", 32'(InstCt), 32'd0);
    @(negedge Clk); @(negedge Clk);
    Reset = 1'b0;
    idle("idle_hold");

    // Launch program 2, five sequential instructions, then HALT
    cyc("launch", 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    check("launch_pc512", 32'(ProgCtr), 32'd512);
    check("launch_running", 32'(Running), 32'd1);
    for (int i = 0; i < 5; i++) idle("seq");
    cyc("halt", 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    check("halt_ack", 32'(Ack), 32'd1);
    check("halt_inst6", 32'(InstCt), 32'd6);
    check("halt_cyc6", 32'(CycleCt), 32'd6);
    check("halt_pc517", 32'(ProgCtr), 32'd517);
    // DONE ignores branch/stall/halt
    cyc("done_ign", 1'b0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 7, 7);
    check("done_pc_hold", 32'(ProgCtr), 32'd517);

    // Branch priority
    cyc("l0", 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    cyc("to100", 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 100, 0);
    cyc("abs_pri", 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 40, -3);
    check("abs_pc40", 32'(ProgCtr), 32'd40);
    cyc("rel_take", 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 'h3FD);
    check("rel_pc37", 32'(ProgCtr), 32'd37);
    cyc("rel_not", 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 'h3FD);
    check("rel_pc38", 32'(ProgCtr), 32'd38);

    // Stall for three cycles at PC=10 with Halt asserted
    cyc("to10", 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10, 0);
    c0 = int'(CycleCt); i0 = int'(InstCt);
    for (int i = 0; i < 3; i++) cyc("stall", 1'b0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5, 5);
    check("stall_pc10", 32'(ProgCtr), 32'd10);
    check("stall_cyc3", 32'(CycleCt), 32'(c0 + 3));
    check("stall_inst0", 32'(InstCt), 32'(i0));
    check("stall_running", 32'(Running), 32'd1);

    // PC wrap
    cyc("to1023", 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1023, 0);
    idle("wrap");
    check("wrap_pc0", 32'(ProgCtr), 32'd0);

    // Saturation on the 4-bit counters, 20 RUN cycles
    cyc("l_sat", 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 20; i++) idle("sat");
    check("sat_cyc4_15", 32'(CycleCt4), 32'd15);
    check("sat_cyc20", 32'(CycleCt), 32'd20);

    // Restart mid-run with program 1
    cyc("restart", 1'b1, 1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 9, 0);
    check("restart_pc256", 32'(ProgCtr), 32'd256);
    check("restart_cyc0", 32'(CycleCt), 32'd0);
    check("restart_inst0", 32'(InstCt), 32'd0);

    // Out-of-range select on the NPROG=3 instance falls back to program 0
    cyc("oob", 1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    check("oob_pc4_0", 32'(ProgCtr4), 32'd0);
    check("oob_pc768", 32'(ProgCtr), 32'd768);

    // Asynchronous reset mid-run, with Start/Halt pulses while held
    idle("pre_rst");
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    check("arst_pc", 32'(ProgCtr), 32'd0);
    check("arst_run", 32'(Running), 32'd0);
    check("arst_cyc", 32'(CycleCt), 32'd0);
    check("arst_inst", 32'(InstCt), 32'd0);
    check("arst_ack", 32'(Ack), 32'd0);
    cyc("rst_start", 1'b1, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    @(negedge Clk);
    Reset = 1'b0; Start = 1'b0; Halt = 1'b0;
    idle("post_rst");
    check("post_rst_run", 32'(Running), 32'd0);
    check("post_rst_pc", 32'(ProgCtr), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      bit st;
      int tg;
      st = ($urandom_range(0, 39) == 0) || (!mRun && ($urandom_range(0, 3) == 0));
      tg = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1020, 1023)) : int'($urandom_range(0, 1023));
      cyc("rnd", st, int'($urandom_range(0, 3)), ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 2) == 0), bit'($urandom_range(0, 1)),
          tg, int'($urandom_range(0, 1023)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
